// File: rtl/barrel_shifter_pkg.sv
//------------------------------------------------------------------------------
// Module   : barrel_shifter_pkg
// Purpose  : Shared types and elaboration helpers for the pipelined barrel
//            shifter (op encoding, mux-level to pipeline-stage mapping).
// Options  : BARREL_SHIFTER_STICKY_EN (used by the shifter, not this package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package barrel_shifter_pkg;

    localparam int OP_W = 2;

    // Encoding 3 is reserved; every consumer decodes it as LOGIC.
    typedef enum logic [OP_W-1:0] {
        LOGIC = 2'd0,
        ARITH = 2'd1,
        ROT   = 2'd2
    } shift_op_t;

    // Mux levels handled by one stage; the remainder goes to the earliest
    // stages, so stage 0 always carries ceil(saw/stages) levels.
    function automatic int levels_in_stage(input int saw, input int stages, input int stage);
        return (saw / stages) + ((stage < (saw % stages)) ? 1 : 0);
    endfunction

    // Index of the first mux level handled by a stage.
    function automatic int first_level(input int saw, input int stages, input int stage);
        int acc;
        acc = 0;
        for (int s = 0; s < stage; s++) begin
            acc += levels_in_stage(saw, stages, s);
        end
        return acc;
    endfunction

    // Stage that owns a given mux level.
    function automatic int stage_of_level(input int saw, input int stages, input int level);
        int st;
        st = 0;
        for (int s = 0; s < stages; s++) begin
            if (level >= first_level(saw, stages, s)) begin
                st = s;
            end
        end
        return st;
    endfunction

endpackage

`default_nettype wire

// File: rtl/barrel_shifter_pipe_if.sv
//------------------------------------------------------------------------------
// Module   : barrel_shifter_pipe_if
// Purpose  : Valid/ready operand and result bundle of the pipelined shifter.
//            master = producer/consumer side, slave = the shifter itself.
// Options  : BARREL_SHIFTER_STICKY_EN adds out_sticky
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface barrel_shifter_pipe_if
    import barrel_shifter_pkg::*;
#(
    parameter int WIDTH = 32
) ();

    localparam int SAW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SAW-1:0]   in_sa;
    logic             in_left;
    logic [OP_W-1:0]  in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef BARREL_SHIFTER_STICKY_EN
    logic             out_sticky;
`endif

    modport master (
        output in_valid, in_data, in_sa, in_left, in_op, out_ready,
        input  in_ready, out_valid, out_data
`ifdef BARREL_SHIFTER_STICKY_EN
        , input out_sticky
`endif
    );

    modport slave (
        input  in_valid, in_data, in_sa, in_left, in_op, out_ready,
        output in_ready, out_valid, out_data
`ifdef BARREL_SHIFTER_STICKY_EN
        , output out_sticky
`endif
    );

endinterface

`default_nettype wire

// File: rtl/barrel_shift_level.sv
//------------------------------------------------------------------------------
// Module   : barrel_shift_level
// Purpose  : One combinational mux level of the barrel shifter: shifts or
//            rotates by DIST when en is set and folds dropped bits into the
//            sticky chain.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module barrel_shift_level
    import barrel_shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  wire  [WIDTH-1:0] data_in,
    input  wire              en,
    input  wire              left,
    input  wire  [OP_W-1:0]  op,
    input  wire              sticky_in,
    output logic [WIDTH-1:0] data_out,
    output logic             sticky_out
);

    logic            w_is_rot;
    logic            w_fill;
    logic [DIST-1:0] w_hi;
    logic [DIST-1:0] w_lo;

    assign w_is_rot = (op == ROT);
    // Sign fill only for arithmetic right; arithmetic left is a plain left.
    assign w_fill   = (op == ARITH) && data_in[WIDTH-1];
    assign w_hi     = data_in[WIDTH-1 -: DIST];
    assign w_lo     = data_in[DIST-1:0];

    // Select shifted/rotated word and accumulate bits that fall off the end.
    // Total shift never exceeds WIDTH-1, so the low bits dropped on a right
    // shift are always original operand bits, never earlier sign fill.
    always_comb begin
        data_out   = data_in;
        sticky_out = sticky_in;
        if (en) begin
            if (w_is_rot) begin
                data_out = left ? {data_in[WIDTH-DIST-1:0], w_hi}
                                : {w_lo, data_in[WIDTH-1:DIST]};
            end else if (left) begin
                data_out   = {data_in[WIDTH-DIST-1:0], {DIST{1'b0}}};
                sticky_out = sticky_in | (|w_hi);
            end else begin
                data_out   = {{DIST{w_fill}}, data_in[WIDTH-1:DIST]};
                sticky_out = sticky_in | (|w_lo);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/barrel_shifter_pipe.sv
//------------------------------------------------------------------------------
// Module   : barrel_shifter_pipe
// Purpose  : Parametrised barrel shifter (logical/arithmetic/rotate) with
//            STAGES register stages and a global-stall valid/ready handshake.
//            Latency is STAGES cycles, throughput one beat per cycle.
// Options  : BARREL_SHIFTER_STICKY_EN adds a pipelined sticky bit
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module barrel_shifter_pipe
    import barrel_shifter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  wire                   clock,
    input  wire                   reset,
    barrel_shifter_pipe_if.slave  bus
);

    localparam int SAW = $clog2(WIDTH);

    // Per-level combinational chain.
    logic [SAW-1:0][WIDTH-1:0] w_lvl_in;
    logic [SAW-1:0][WIDTH-1:0] w_lvl_out;
    logic [SAW-1:0]            w_lvl_en;
    logic [SAW-1:0]            w_lvl_left;
    logic [SAW-1:0][OP_W-1:0]  w_lvl_op;
    logic [SAW-1:0]            w_lvl_sticky_in;
    logic [SAW-1:0]            w_lvl_sticky_out;

    // Stage outputs feeding the stage registers.
    logic [WIDTH-1:0]          w_stage_data [STAGES];

    // Stage registers: partial result plus the control still needed.
    logic                      r_valid [STAGES];
    logic [WIDTH-1:0]          r_data  [STAGES];
    logic [SAW-1:0]            r_sa    [STAGES];
    logic                      r_left  [STAGES];
    logic [OP_W-1:0]           r_op    [STAGES];
`ifdef BARREL_SHIFTER_STICKY_EN
    logic                      w_stage_sticky [STAGES];
    logic                      r_sticky       [STAGES];
`else
    logic                      w_unused_sticky;
    assign w_unused_sticky = |w_lvl_sticky_out;
`endif

    logic                      w_stall;

    // One stalled output freezes the whole pipe; in_ready is its inverse.
    assign w_stall      = r_valid[STAGES-1] && !bus.out_ready;
    assign bus.in_ready = !w_stall;

    for (genvar k = 0; k < SAW; k++) begin : g_level
        localparam int S     = stage_of_level(SAW, STAGES, k);
        localparam bit FIRST = (first_level(SAW, STAGES, S) == k);

        if (S == 0) begin : g_ctl_in
            assign w_lvl_en[k]   = bus.in_sa[k];
            assign w_lvl_left[k] = bus.in_left;
            assign w_lvl_op[k]   = bus.in_op;
        end else begin : g_ctl_reg
            assign w_lvl_en[k]   = r_sa[S-1][k];
            assign w_lvl_left[k] = r_left[S-1];
            assign w_lvl_op[k]   = r_op[S-1];
        end

        if (FIRST && (S == 0)) begin : g_src_in
            assign w_lvl_in[k]        = bus.in_data;
            assign w_lvl_sticky_in[k] = 1'b0;
        end else if (FIRST) begin : g_src_reg
            assign w_lvl_in[k]        = r_data[S-1];
`ifdef BARREL_SHIFTER_STICKY_EN
            assign w_lvl_sticky_in[k] = r_sticky[S-1];
`else
            assign w_lvl_sticky_in[k] = 1'b0;
`endif
        end else begin : g_src_chain
            assign w_lvl_in[k]        = w_lvl_out[k-1];
            assign w_lvl_sticky_in[k] = w_lvl_sticky_out[k-1];
        end

        barrel_shift_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_level (
            .data_in    (w_lvl_in[k]),
            .en         (w_lvl_en[k]),
            .left       (w_lvl_left[k]),
            .op         (w_lvl_op[k]),
            .sticky_in  (w_lvl_sticky_in[k]),
            .data_out   (w_lvl_out[k]),
            .sticky_out (w_lvl_sticky_out[k])
        );
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_tap
        localparam int LAST = first_level(SAW, STAGES, s) + levels_in_stage(SAW, STAGES, s) - 1;
        assign w_stage_data[s] = w_lvl_out[LAST];
`ifdef BARREL_SHIFTER_STICKY_EN
        assign w_stage_sticky[s] = w_lvl_sticky_out[LAST];
`endif
    end

    // Advance every stage together unless the output is back-pressured.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < STAGES; s++) begin
                r_valid[s]  <= 1'b0;
                r_data[s]   <= '0;
                r_sa[s]     <= '0;
                r_left[s]   <= 1'b0;
                r_op[s]     <= '0;
`ifdef BARREL_SHIFTER_STICKY_EN
                r_sticky[s] <= 1'b0;
`endif
            end
        end else if (!w_stall) begin
            r_valid[0]  <= bus.in_valid;
            r_data[0]   <= w_stage_data[0];
            r_sa[0]     <= bus.in_sa;
            r_left[0]   <= bus.in_left;
            r_op[0]     <= bus.in_op;
`ifdef BARREL_SHIFTER_STICKY_EN
            r_sticky[0] <= w_stage_sticky[0];
`endif
            for (int s = 1; s < STAGES; s++) begin
                r_valid[s]  <= r_valid[s-1];
                r_data[s]   <= w_stage_data[s];
                r_sa[s]     <= r_sa[s-1];
                r_left[s]   <= r_left[s-1];
                r_op[s]     <= r_op[s-1];
`ifdef BARREL_SHIFTER_STICKY_EN
                r_sticky[s] <= w_stage_sticky[s];
`endif
            end
        end
    end

    assign bus.out_valid  = r_valid[STAGES-1];
    assign bus.out_data   = r_data[STAGES-1];
`ifdef BARREL_SHIFTER_STICKY_EN
    assign bus.out_sticky = r_sticky[STAGES-1];
`endif

endmodule

`default_nettype wire

// File: tb/tb_barrel_shifter_pipe.sv
//------------------------------------------------------------------------------
// Module   : tb_barrel_shifter_pipe
// Purpose  : Self-checking bench: directed 8-bit/3-stage cases plus random
//            streams over several WIDTH/STAGES configurations, all checked
//            against an arithmetic reference model.
// Options  : BARREL_SHIFTER_STICKY_EN enables sticky comparisons
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_barrel_shifter_pipe;

    localparam int MW  = 8;
    localparam int MST = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic sweep_rst;
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   sweep_done = 0;

    barrel_shifter_pipe_if #(.WIDTH(MW)) m_if ();

    barrel_shifter_pipe #(
        .WIDTH  (MW),
        .STAGES (MST)
    ) u_dut (
        .clock (clk),
        .reset (rst),
        .bus   (m_if.slave)
    );

    task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference: whole-word shift with plain arithmetic on a 64-bit container.
    function automatic void ref_shift(input int w, input longint unsigned d_in, input int sa,
                                      input bit left, input int op,
                                      output longint unsigned res, output bit sticky);
        longint unsigned mask;
        longint unsigned d;
        longint unsigned full;
        mask   = (64'd1 << w) - 64'd1;
        d      = d_in & mask;
        res    = 0;
        sticky = 1'b0;
        if (op == 2) begin
            if (left) res = ((d << sa) | (d >> (w - sa))) & mask;
            else      res = ((d >> sa) | (d << (w - sa))) & mask;
        end else if (left) begin
            full   = d << sa;
            res    = full & mask;
            sticky = (full >> w) != 0;
        end else begin
            res    = d >> sa;
            sticky = (d & ((64'd1 << sa) - 64'd1)) != 0;
            if (op == 1 && ((d >> (w - 1)) & 64'd1) != 0) res = res | (mask & ~(mask >> sa));
        end
    endfunction

    task automatic main_idle();
        m_if.in_valid  = 1'b0;
        m_if.in_data   = '0;
        m_if.in_sa     = '0;
        m_if.in_left   = 1'b0;
        m_if.in_op     = '0;
        m_if.out_ready = 1'b1;
    endtask

    task automatic main_random_beat();
        m_if.in_valid = 1'b1;
        m_if.in_data  = 8'($urandom);
        m_if.in_sa    = 3'($urandom);
        m_if.in_left  = 1'($urandom);
        m_if.in_op    = 2'($urandom_range(0, 3));
    endtask

    task automatic send_one(input string tag, input logic [7:0] d, input int sa, input bit left,
                            input int op, input logic [7:0] exp_d, input bit exp_s);
        int lat;
        @(negedge clk);
        m_if.in_valid  = 1'b1;
        m_if.in_data   = d;
        m_if.in_sa     = 3'(sa);
        m_if.in_left   = left;
        m_if.in_op     = 2'(op);
        m_if.out_ready = 1'b1;
        #1 check_value({tag, "_rdy"}, 64'(m_if.in_ready), 64'd1);
        @(negedge clk);
        m_if.in_valid = 1'b0;
        lat = 1;
        while (!m_if.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        #1;
        check_value({tag, "_lat"}, 64'(lat), 64'(MST));
        check_value({tag, "_data"}, 64'(m_if.out_data), 64'(exp_d));
`ifdef BARREL_SHIFTER_STICKY_EN
        check_value({tag, "_sticky"}, 64'(m_if.out_sticky), 64'(exp_s));
`else
        if (exp_s) begin end
`endif
    endtask

    task automatic push_expected(inout longint unsigned dq[$], inout bit sq[$]);
        longint unsigned r;
        bit              s;
        ref_shift(MW, 64'(m_if.in_data), int'(m_if.in_sa), m_if.in_left, int'(m_if.in_op), r, s);
        dq.push_back(r);
        sq.push_back(s);
    endtask

    task automatic pop_compare(input string tag, inout longint unsigned dq[$], inout bit sq[$]);
        if (dq.size() == 0) begin
            check_value({tag, "_spurious"}, 64'(m_if.out_valid), 64'd0);
        end else begin
            check_value(tag, 64'(m_if.out_data), dq.pop_front());
`ifdef BARREL_SHIFTER_STICKY_EN
            check_value({tag, "_sticky"}, 64'(m_if.out_sticky), 64'(sq.pop_front()));
`else
            void'(sq.pop_front());
`endif
        end
    endtask

    task automatic stream_test();
        longint unsigned dq[$];
        bit              sq[$];
        int got = 0, first = -1, last = -1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (i < 16) main_random_beat();
            else        m_if.in_valid = 1'b0;
            m_if.out_ready = 1'b1;
            #1;
            if (i < 16) check_value("stream_rdy", 64'(m_if.in_ready), 64'd1);
            if (m_if.out_valid) begin
                pop_compare("stream_data", dq, sq);
                got++;
                if (first < 0) first = i;
                last = i;
            end
            if (m_if.in_valid && m_if.in_ready) push_expected(dq, sq);
        end
        check_value("stream_count", 64'(got), 64'd16);
        check_value("stream_span", 64'(last - first), 64'd15);
    endtask

    task automatic backpressure_test();
        longint unsigned dq[$];
        bit              sq[$];
        logic [7:0] held;
        int got = 0;
        held = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i < 3) main_random_beat();
            else       m_if.in_valid = 1'b0;
            m_if.out_ready = !(i >= 3 && i < 8);
            #1;
            if (i == 3) begin
                held = m_if.out_data;
                check_value("bp_first", 64'(m_if.out_data), (dq.size() > 0) ? dq[0] : 64'hDEAD);
            end
            if (i >= 3 && i < 8) begin
                check_value("bp_rdy", 64'(m_if.in_ready), 64'd0);
                check_value("bp_valid", 64'(m_if.out_valid), 64'd1);
                if (i > 3) check_value("bp_hold", 64'(m_if.out_data), 64'(held));
            end
            if (m_if.out_valid && m_if.out_ready) begin
                pop_compare("bp_data", dq, sq);
                got++;
            end
            if (m_if.in_valid && m_if.in_ready) push_expected(dq, sq);
        end
        check_value("bp_count", 64'(got), 64'd3);
    endtask

    task automatic reset_test();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            main_random_beat();
            m_if.out_ready = 1'b1;
        end
        @(negedge clk);
        rst           = 1'b1;
        m_if.in_valid = 1'b1;
        m_if.in_data  = 8'hFF;
        #1 check_value("rst_in_rdy", 64'(m_if.in_ready), 64'd1);
        @(negedge clk);
        rst           = 1'b0;
        m_if.in_valid = 1'b0;
        #1;
        check_value("rst_valid", 64'(m_if.out_valid), 64'd0);
        check_value("rst_data", 64'(m_if.out_data), 64'd0);
        check_value("rst_rdy", 64'(m_if.in_ready), 64'd1);
`ifdef BARREL_SHIFTER_STICKY_EN
        check_value("rst_sticky", 64'(m_if.out_sticky), 64'd0);
`endif
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1 check_value("rst_drop", 64'(m_if.out_valid), 64'd0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        sweep_rst = 1'b1;
        main_idle();
        m_if.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        m_if.in_valid = 1'b0;
        rst       = 1'b0;
        sweep_rst = 1'b0;
        #1;
        check_value("reset_valid", 64'(m_if.out_valid), 64'd0);
        check_value("reset_data", 64'(m_if.out_data), 64'd0);
        check_value("reset_rdy", 64'(m_if.in_ready), 64'd1);
`ifdef BARREL_SHIFTER_STICKY_EN
        check_value("reset_sticky", 64'(m_if.out_sticky), 64'd0);
`endif

        send_one("r_logic", 8'hB2, 3, 1'b0, 0, 8'h16, 1'b1);
        send_one("r_arith", 8'hB2, 3, 1'b0, 1, 8'hF6, 1'b1);
        send_one("r_rot",   8'hB2, 3, 1'b0, 2, 8'h56, 1'b0);
        send_one("r_resv",  8'hB2, 3, 1'b0, 3, 8'h16, 1'b1);
        send_one("l_logic", 8'hB2, 2, 1'b1, 0, 8'hC8, 1'b1);
        send_one("l_arith", 8'hB2, 2, 1'b1, 1, 8'hC8, 1'b1);
        send_one("l_rot",   8'hB2, 3, 1'b1, 2, 8'h95, 1'b0);
        send_one("r_max",   8'h80, 7, 1'b0, 1, 8'hFF, 1'b0);
        for (int op = 0; op < 4; op++) begin
            for (int l = 0; l < 2; l++) begin
                send_one($sformatf("sa0_op%0d_l%0d", op, l), 8'hB2, 0, 1'(l), op, 8'hB2, 1'b0);
            end
        end

        stream_test();
        backpressure_test();
        reset_test();

        for (int t = 0; t < 3000 && sweep_done < 6; t++) @(negedge clk);
        check_value("sweep_done", 64'(sweep_done), 64'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    for (genvar gi = 0; gi < 6; gi++) begin : g_sweep
        localparam int W  = (gi < 2) ? 4 : ((gi < 4) ? 16 : 32);
        localparam int SW = $clog2(W);
        localparam int ST = ((gi % 2) == 0) ? 1 : SW;

        barrel_shifter_pipe_if #(.WIDTH(W)) s_if ();

        barrel_shifter_pipe #(
            .WIDTH  (W),
            .STAGES (ST)
        ) u_dut (
            .clock (clk),
            .reset (sweep_rst),
            .bus   (s_if.slave)
        );

        longint unsigned exp_d_q[$];
        bit              exp_s_q[$];
        int              acc_q[$];

        initial begin : p_stim
            longint unsigned r;
            bit              s;
            int              edge_no;
            int              acc;
            s_if.in_valid  = 1'b0;
            s_if.in_data   = '0;
            s_if.in_sa     = '0;
            s_if.in_left   = 1'b0;
            s_if.in_op     = '0;
            s_if.out_ready = 1'b1;
            wait (sweep_rst === 1'b0);
            edge_no = 0;
            for (int cyc = 0; cyc < 420; cyc++) begin
                @(negedge clk);
                s_if.out_ready = (cyc < 200 || cyc >= 380) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
                s_if.in_valid  = (cyc < 380) && ($urandom_range(0, 3) != 0);
                s_if.in_data   = W'($urandom);
                s_if.in_sa     = SW'($urandom_range(0, W - 1));
                s_if.in_left   = 1'($urandom);
                s_if.in_op     = 2'($urandom_range(0, 3));
                #1;
                if (s_if.out_valid && s_if.out_ready) begin
                    if (exp_d_q.size() == 0) begin
                        check_value($sformatf("sw%0d_spurious", gi), 64'(s_if.out_valid), 64'd0);
                    end else begin
                        acc = acc_q.pop_front();
                        check_value($sformatf("sw%0d_data", gi), 64'(s_if.out_data), exp_d_q.pop_front());
`ifdef BARREL_SHIFTER_STICKY_EN
                        check_value($sformatf("sw%0d_sticky", gi), 64'(s_if.out_sticky), 64'(exp_s_q.pop_front()));
`else
                        void'(exp_s_q.pop_front());
`endif
                        if (cyc < 200) begin
                            check_value($sformatf("sw%0d_lat", gi), 64'(edge_no - acc + 1), 64'(ST));
                        end
                    end
                end
                if (s_if.in_valid && s_if.in_ready) begin
                    ref_shift(W, 64'(s_if.in_data), int'(s_if.in_sa), s_if.in_left, int'(s_if.in_op), r, s);
                    exp_d_q.push_back(r);
                    exp_s_q.push_back(s);
                    acc_q.push_back(edge_no + 1);
                end
                edge_no++;
            end
            check_value($sformatf("sw%0d_drain", gi), 64'(exp_d_q.size()), 64'd0);
            sweep_done++;
        end
    end

endmodule

`default_nettype wire
